// File: rtl/lwc_pkg.sv
// Shared constants and elaboration helpers for the LWC width adapter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lwc_pkg;

    localparam int LWC_BYTE = 8;

    // Number of core bytes carried by one external word of width w.
    function automatic int nbytes(input int w);
        return w / LWC_BYTE;
    endfunction

    // Byte-index counter width; a 1-byte bus still gets a 1-bit counter so
    // the counter never collapses to a zero-width vector.
    function automatic int cnt_width(input int w);
        return (nbytes(w) > 1) ? $clog2(nbytes(w)) : 1;
    endfunction

    // Legal external widths: whole bytes, 8..128 bits.
    function automatic bit width_ok(input int w);
        return ((w % LWC_BYTE) == 0) && (w >= 8) && (w <= 128);
    endfunction

endpackage

// File: rtl/lwc_width_adapter_downsizer.sv
// Word-to-byte serialiser: holds one W-bit word and presents it MSB byte first.
// Latency: word accepted at cycle t, byte 0 presented at t+1, then 1 byte/cycle.
// Backpressure: out_ready stalls the current byte; in_ready reopens in the last-byte cycle.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_data/valid/ready    W-bit word side (external)
//   out_data/valid/ready   byte side (core)
module lwc_downsizer
    import lwc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int N  = nbytes(W);
    localparam int CW = cnt_width(W);

    // word_q shifts left as bytes leave, so the current byte is always the top
    // lane; cnt_q tracks how many bytes of the word have been consumed.
    logic [W-1:0]  word_q;
    logic          full_q;
    logic [CW-1:0] cnt_q;
    logic          last_byte;
    logic          in_fire;
    logic          out_fire;

    assign last_byte = (cnt_q == CW'(N - 1));

    // Reset forces every handshake output low, even before the first edge
    // has cleared the registers.
    assign out_valid = full_q && !rst;
    assign out_data  = word_q[W-1 -: 8];
    assign in_ready  = !rst && (!full_q || (last_byte && out_ready));

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            full_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (out_fire) begin
                if (last_byte) begin
                    cnt_q  <= '0;
                    full_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_q + CW'(1);
                    word_q <= word_q << LWC_BYTE;
                end
            end
            // A reload only happens when empty or in the final-byte cycle,
            // so it always wins over the shift/clear above.
            if (in_fire) begin
                word_q <= in_data;
                full_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lwc_width_adapter.sv
// Adapts PW/SW-bit LWC buses to a byte-serial core: PDI/SDI serialised, DO packed.
// Latency: 1 cycle per direction (word in -> byte 0 out; completing byte in -> word out).
// Backpressure: valid/ready on every side; do_ready low stalls core_do_ready once the output register is full.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   pdi_* / sdi_*                 external public / secret words (in)
//   do_data/valid/ready/last      external output words, do_last marks the final word
//   core_pdi_* / core_sdi_*       bytes towards the core
//   core_do_*                     bytes from the core, core_do_last marks the final byte
module lwc_width_adapter
    import lwc_pkg::*;
#(
    parameter int PW = 32,
    parameter int SW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] pdi_data,
    input  logic          pdi_valid,
    output logic          pdi_ready,
    input  logic [SW-1:0] sdi_data,
    input  logic          sdi_valid,
    output logic          sdi_ready,
    output logic [PW-1:0] do_data,
    output logic          do_valid,
    input  logic          do_ready,
    output logic          do_last,
    output logic [7:0]    core_pdi_data,
    output logic          core_pdi_valid,
    input  logic          core_pdi_ready,
    output logic [7:0]    core_sdi_data,
    output logic          core_sdi_valid,
    input  logic          core_sdi_ready,
    input  logic [7:0]    core_do_data,
    input  logic          core_do_valid,
    output logic          core_do_ready,
    input  logic          core_do_last
);

    if (!width_ok(PW)) begin : g_bad_pw
        $error("lwc_width_adapter: PW must be a multiple of 8 in 8..128");
    end
    if (!width_ok(SW)) begin : g_bad_sw
        $error("lwc_width_adapter: SW must be a multiple of 8 in 8..128");
    end

    // ------------------------------------------------------------------
    // PDI / SDI: word-to-byte serialisers
    // ------------------------------------------------------------------
    lwc_downsizer #(.W(PW)) u_pdi_dn (
        .clk       (clk),
        .rst       (rst),
        .in_data   (pdi_data),
        .in_valid  (pdi_valid),
        .in_ready  (pdi_ready),
        .out_data  (core_pdi_data),
        .out_valid (core_pdi_valid),
        .out_ready (core_pdi_ready)
    );

    lwc_downsizer #(.W(SW)) u_sdi_dn (
        .clk       (clk),
        .rst       (rst),
        .in_data   (sdi_data),
        .in_valid  (sdi_valid),
        .in_ready  (sdi_ready),
        .out_data  (core_sdi_data),
        .out_valid (core_sdi_valid),
        .out_ready (core_sdi_ready)
    );

    // ------------------------------------------------------------------
    // DO: byte-to-word packer
    // ------------------------------------------------------------------
    localparam int DN  = nbytes(PW);
    localparam int DCW = cnt_width(PW);

    logic [PW-1:0]  asm_q;
    logic [PW-1:0]  asm_next;
    logic [PW-1:0]  byte_ext;
    logic [PW-1:0]  out_q;
    logic [DCW-1:0] dcnt_q;
    logic           do_valid_q;
    logic           do_last_q;
    logic           lane_last;
    logic           byte_fire;
    logic           word_done;

    // The core may only push while the output register is free or draining,
    // so a completed word never overwrites one the sink has not taken.
    assign core_do_ready = !rst && (!do_valid_q || do_ready);
    assign do_valid      = do_valid_q && !rst;
    assign do_last       = do_last_q && !rst;
    assign do_data       = out_q;

    assign byte_fire = core_do_valid && core_do_ready;
    assign lane_last = (dcnt_q == DCW'(DN - 1));
    // core_do_last flushes a partial word: bytes stay left-aligned and the
    // unused low lanes keep the zeros left by the previous clear.
    assign word_done = byte_fire && (lane_last || core_do_last);

    always_comb begin
        byte_ext = PW'(core_do_data) << (PW - LWC_BYTE);
        asm_next = asm_q | (byte_ext >> {dcnt_q, 3'b000});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q      <= '0;
            out_q      <= '0;
            dcnt_q     <= '0;
            do_valid_q <= 1'b0;
            do_last_q  <= 1'b0;
        end else begin
            if (do_valid_q && do_ready) begin
                do_valid_q <= 1'b0;
                do_last_q  <= 1'b0;
            end
            if (byte_fire) begin
                if (word_done) begin
                    out_q      <= asm_next;
                    do_valid_q <= 1'b1;
                    do_last_q  <= core_do_last;
                    asm_q      <= '0;
                    dcnt_q     <= '0;
                end else begin
                    asm_q      <= asm_next;
                    dcnt_q     <= dcnt_q + DCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lwc_width_adapter.sv
module tb_lwc_width_adapter;

    localparam int PW = 32;
    localparam int SW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic [PW-1:0] pdi_data;
    logic          pdi_valid, pdi_ready;
    logic [SW-1:0] sdi_data;
    logic          sdi_valid, sdi_ready;
    logic [PW-1:0] do_data;
    logic          do_valid, do_ready, do_last;
    logic [7:0]    core_pdi_data, core_sdi_data, core_do_data;
    logic          core_pdi_valid, core_pdi_ready;
    logic          core_sdi_valid, core_sdi_ready;
    logic          core_do_valid, core_do_ready, core_do_last;

    // 8-bit instance
    logic [7:0] b_pdi_data, b_sdi_data, b_do_data;
    logic       b_pdi_valid, b_pdi_ready, b_sdi_valid, b_sdi_ready;
    logic       b_do_valid, b_do_ready, b_do_last;
    logic [7:0] b_core_pdi_data, b_core_sdi_data, b_core_do_data;
    logic       b_core_pdi_valid, b_core_pdi_ready;
    logic       b_core_sdi_valid, b_core_sdi_ready;
    logic       b_core_do_valid, b_core_do_ready, b_core_do_last;

    lwc_width_adapter #(.PW(PW), .SW(SW)) dut (
        .clk(clk), .rst(rst),
        .pdi_data(pdi_data), .pdi_valid(pdi_valid), .pdi_ready(pdi_ready),
        .sdi_data(sdi_data), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
        .do_data(do_data), .do_valid(do_valid), .do_ready(do_ready), .do_last(do_last),
        .core_pdi_data(core_pdi_data), .core_pdi_valid(core_pdi_valid), .core_pdi_ready(core_pdi_ready),
        .core_sdi_data(core_sdi_data), .core_sdi_valid(core_sdi_valid), .core_sdi_ready(core_sdi_ready),
        .core_do_data(core_do_data), .core_do_valid(core_do_valid), .core_do_ready(core_do_ready),
        .core_do_last(core_do_last)
    );

    lwc_width_adapter #(.PW(8), .SW(8)) dut8 (
        .clk(clk), .rst(rst),
        .pdi_data(b_pdi_data), .pdi_valid(b_pdi_valid), .pdi_ready(b_pdi_ready),
        .sdi_data(b_sdi_data), .sdi_valid(b_sdi_valid), .sdi_ready(b_sdi_ready),
        .do_data(b_do_data), .do_valid(b_do_valid), .do_ready(b_do_ready), .do_last(b_do_last),
        .core_pdi_data(b_core_pdi_data), .core_pdi_valid(b_core_pdi_valid), .core_pdi_ready(b_core_pdi_ready),
        .core_sdi_data(b_core_sdi_data), .core_sdi_valid(b_core_sdi_valid), .core_sdi_ready(b_core_sdi_ready),
        .core_do_data(b_core_do_data), .core_do_valid(b_core_do_valid), .core_do_ready(b_core_do_ready),
        .core_do_last(b_core_do_last)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  pdi_q[$];
    logic [7:0]  sdi_q[$];
    logic [32:0] do_q[$];   // {last, word}

    logic [7:0] t2b[4] = '{8'h00, 8'h11, 8'h22, 8'h33};
    logic [7:0] t3b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] t4b[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] t6b[4] = '{8'h3C, 8'h5A, 8'h96, 8'hF0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pdi(input logic [31:0] w);
        for (int i = 0; i < 4; i++) pdi_q.push_back(w[31 - 8*i -: 8]);
    endtask

    task automatic push_sdi(input logic [31:0] w);
        for (int i = 0; i < 4; i++) sdi_q.push_back(w[31 - 8*i -: 8]);
    endtask

    task automatic chk_in_reset(input string pre);
        check({pre, "_rst_pdi_ready"},      pdi_ready,      0);
        check({pre, "_rst_sdi_ready"},      sdi_ready,      0);
        check({pre, "_rst_core_do_ready"},  core_do_ready,  0);
        check({pre, "_rst_core_pdi_valid"}, core_pdi_valid, 0);
        check({pre, "_rst_core_sdi_valid"}, core_sdi_valid, 0);
        check({pre, "_rst_do_valid"},       do_valid,       0);
        check({pre, "_rst_b_pdi_ready"},    b_pdi_ready,    0);
    endtask

    task automatic chk_after_reset(input string pre);
        check({pre, "_post_pdi_ready"},      pdi_ready,      1);
        check({pre, "_post_sdi_ready"},      sdi_ready,      1);
        check({pre, "_post_core_do_ready"},  core_do_ready,  1);
        check({pre, "_post_core_pdi_valid"}, core_pdi_valid, 0);
        check({pre, "_post_core_sdi_valid"}, core_sdi_valid, 0);
        check({pre, "_post_do_valid"},       do_valid,       0);
        check({pre, "_post_do_last"},        do_last,        0);
        check({pre, "_post_do_data"},        do_data,        0);
    endtask

    // Scoreboard monitors: every byte/word that crosses a handshake is
    // compared with the next expected entry.
    always @(negedge clk) begin
        if (core_pdi_valid && core_pdi_ready) begin
            if (pdi_q.size() == 0) check("pdi_extra_byte", pdi_q.size(), 1);
            else                   check("pdi_byte", core_pdi_data, pdi_q.pop_front());
        end
        if (core_sdi_valid && core_sdi_ready) begin
            if (sdi_q.size() == 0) check("sdi_extra_byte", sdi_q.size(), 1);
            else                   check("sdi_byte", core_sdi_data, sdi_q.pop_front());
        end
        if (do_valid && do_ready) begin
            if (do_q.size() == 0) check("do_extra_word", do_q.size(), 1);
            else                  check("do_word", {do_last, do_data}, do_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pdi_data = '0; pdi_valid = 0; sdi_data = '0; sdi_valid = 0; do_ready = 1;
        core_pdi_ready = 0; core_sdi_ready = 0;
        core_do_data = '0; core_do_valid = 0; core_do_last = 0;
        b_pdi_data = '0; b_pdi_valid = 0; b_sdi_data = '0; b_sdi_valid = 0; b_do_ready = 1;
        b_core_pdi_ready = 1; b_core_sdi_ready = 1;
        b_core_do_data = '0; b_core_do_valid = 0; b_core_do_last = 0;

        // Reset state
        repeat (2) begin
            @(negedge clk);
            chk_in_reset("init");
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_after_reset("init");

        // T1: PDI serialisation, back-to-back words with no bubble
        tick();
        core_pdi_ready = 1;
        pdi_data = 32'hA1B2C3D4; pdi_valid = 1; push_pdi(32'hA1B2C3D4);
        @(negedge clk);
        check("t1_ready_empty", pdi_ready, 1);
        check("t1_valid_empty", core_pdi_valid, 0);
        tick();
        pdi_data = 32'h01020304; push_pdi(32'h01020304);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_pdi_ready_w0", pdi_ready, (k == 3));
            check("t1_core_valid_w0", core_pdi_valid, 1);
            tick();
        end
        pdi_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_core_valid_w1", core_pdi_valid, 1);
            check("t1_pdi_ready_w1", pdi_ready, (k == 3));
            tick();
        end
        @(negedge clk);
        check("t1_core_valid_idle", core_pdi_valid, 0);

        // T2: SDI with a toggling core ready; bytes hold while stalled
        tick();
        sdi_data = 32'h00112233; sdi_valid = 1; push_sdi(32'h00112233);
        @(negedge clk);
        check("t2_sdi_ready_empty", sdi_ready, 1);
        tick();
        sdi_valid = 0;
        for (int i = 0; i < 8; i++) begin
            core_sdi_ready = (i % 2 == 0);
            @(negedge clk);
            check("t2_core_valid", core_sdi_valid, (i < 7));
            if (i < 7) check("t2_core_byte", core_sdi_data, t2b[(i + 1) / 2]);
            check("t2_sdi_ready", sdi_ready, (i >= 6));
            tick();
        end
        core_sdi_ready = 1;

        // T3: DO packing with a partial, left-aligned final word
        do_ready = 1;
        do_q.push_back({1'b0, 32'h11223344});
        do_q.push_back({1'b1, 32'h55000000});
        for (int k = 0; k < 5; k++) begin
            core_do_valid = 1; core_do_data = t3b[k]; core_do_last = (k == 4);
            @(negedge clk);
            check("t3_core_do_ready", core_do_ready, 1);
            check("t3_do_valid", do_valid, (k == 4));
            tick();
        end
        core_do_valid = 0; core_do_last = 0;
        @(negedge clk);
        check("t3_last_valid", do_valid, 1);
        check("t3_last_flag", do_last, 1);
        tick();
        @(negedge clk);
        check("t3_drained", do_valid, 0);
        check("t3_last_clear", do_last, 0);

        // T4: DO backpressure holds the word and stalls the core
        tick();
        do_ready = 0;
        do_q.push_back({1'b0, 32'hAABBCCDD});
        for (int k = 0; k < 4; k++) begin
            core_do_valid = 1; core_do_data = t4b[k]; core_do_last = 0;
            @(negedge clk);
            check("t4_core_do_ready_fill", core_do_ready, 1);
            tick();
        end
        core_do_data = 8'hEE; core_do_last = 1;
        do_q.push_back({1'b1, 32'hEE000000});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_core_do_ready_stall", core_do_ready, 0);
            check("t4_do_valid_hold", do_valid, 1);
            check("t4_do_data_hold", do_data, 32'hAABBCCDD);
            tick();
        end
        do_ready = 1;
        @(negedge clk);
        check("t4_core_do_ready_release", core_do_ready, 1);
        tick();
        core_do_valid = 0; core_do_last = 0;
        @(negedge clk);
        check("t4_tail_valid", do_valid, 1);
        check("t4_tail_data", do_data, 32'hEE000000);
        tick();
        @(negedge clk);
        check("t4_drained", do_valid, 0);

        // T5: reset in the middle of a PDI word
        tick();
        pdi_data = 32'hDEADBEEF; pdi_valid = 1; push_pdi(32'hDEADBEEF);
        @(negedge clk);
        check("t5_pdi_ready", pdi_ready, 1);
        tick();
        pdi_valid = 0;
        repeat (2) begin
            @(negedge clk);
            tick();
        end
        rst = 1;
        pdi_data = 32'h55555555; pdi_valid = 1;
        repeat (2) begin
            @(negedge clk);
            chk_in_reset("t5");
            tick();
        end
        check("t5_bytes_before_rst", pdi_q.size(), 2);
        pdi_q.delete();
        rst = 0; pdi_valid = 0;
        @(negedge clk);
        chk_after_reset("t5");
        tick();
        pdi_data = 32'h01234567; pdi_valid = 1; push_pdi(32'h01234567);
        @(negedge clk);
        check("t5_new_word_ready", pdi_ready, 1);
        tick();
        pdi_valid = 0;
        repeat (5) begin
            @(negedge clk);
            tick();
        end

        // T6: 8-bit instance is a one-cycle pass-through
        for (int k = 0; k < 5; k++) begin
            b_pdi_valid = (k < 4);
            b_pdi_data = t6b[k % 4];
            b_core_do_valid = (k < 4);
            b_core_do_data = t6b[k % 4] ^ 8'hFF;
            b_core_do_last = (k == 3);
            @(negedge clk);
            check("t6_pdi_ready", b_pdi_ready, 1);
            check("t6_core_pdi_valid", b_core_pdi_valid, (k > 0));
            check("t6_do_valid", b_do_valid, (k > 0));
            if (k > 0) begin
                check("t6_core_pdi_data", b_core_pdi_data, t6b[k - 1]);
                check("t6_do_data", b_do_data, t6b[k - 1] ^ 8'hFF);
                check("t6_do_last", b_do_last, (k == 4));
            end
            tick();
        end
        b_pdi_valid = 0; b_core_do_valid = 0; b_core_do_last = 0;
        @(negedge clk);
        check("t6_idle_core_valid", b_core_pdi_valid, 0);
        check("t6_idle_do_valid", b_do_valid, 0);

        check("end_pdi_q_empty", pdi_q.size(), 0);
        check("end_sdi_q_empty", sdi_q.size(), 0);
        check("end_do_q_empty", do_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lwc_width_adapter.md
Name: lwc_width_adapter

Overview:
- Parametrised bus-width adapter between the external LWC interfaces and the existing byte-serial Romulus controller/datapath pair.
- PDI and SDI words of PW/SW bits are serialised into bytes for the core.
- Core output bytes are packed into PW-bit DO words, so one core serves 8/16/32/64-bit LWC buses.
- Sits at the top level between the pins and the byte-wide api/datapath pair; adds buffering, backpressure and last-word packing the byte-only wrapper lacks.

Parameters:
- PW, 32, PDI/DO external width in bits; multiple of 8, 8..128.
- SW, 32, SDI external width in bits; multiple of 8, 8..128.

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- pdi_data  in  PW  external public data word
- pdi_valid  in  1  word valid
- pdi_ready  out  1  word accepted when valid&ready
- sdi_data  in  SW  external secret data word
- sdi_valid  in  1  word valid
- sdi_ready  out  1  word accepted when valid&ready
- do_data  out  PW  external output word
- do_valid  out  1  output word valid
- do_ready  in  1  sink accepts word
- do_last  out  1  final word of output segment/tag
- core_pdi_data  out  8  byte to core
- core_pdi_valid  out  1  byte valid
- core_pdi_ready  in  1  core accepts byte
- core_sdi_data  out  8  key byte to core
- core_sdi_valid  out  1  byte valid
- core_sdi_ready  in  1  core accepts byte
- core_do_data  in  8  byte from core
- core_do_valid  in  1  byte valid
- core_do_ready  out  1  adapter accepts byte
- core_do_last  in  1  final byte of output

Behaviour:
- Reset: all state cleared; partial words discarded. While rst=1, every valid/ready output is 0. First cycle after rst: pdi_ready=sdi_ready=1, core_do_ready=1, all valids 0, do_last=0, do_data=0.
- All transfers are valid&ready. Valid never depends on ready. Data is held stable while valid&!ready.
- Downsizer (PDI and SDI, N=W/8):
  - Word register, full flag, byte index cnt (0..N-1).
  - Byte order is MSB first: byte k = word[W-1-8k -: 8].
  - core_*_valid = full; core_*_data = byte[cnt].
  - Core accepts byte: if cnt<N-1, cnt+1; else cnt=0 and full clears unless reloaded in the same cycle.
  - ext_ready = !full || (cnt==N-1 && core_*_ready), giving back-to-back words with no bubble (1 byte/cycle).
  - Latency: word accepted at cycle t; byte 0 presented at t+1.
  - N=1 degenerates to a one-entry pipeline register.
- Upsizer (DO, N=PW/8):
  - Assembly shift register, cnt, plus output register with do_valid/do_last.
  - core_do_ready = !do_valid || do_ready.
  - Accepted byte written to lane cnt (MSB lane first).
  - The word completes when cnt==N-1 or core_do_last=1. On completion: load the output register, set do_valid, do_last=core_do_last, cnt=0, clear assembly.
  - Partial last word is left-aligned; unused low bytes are 0.
  - Latency: completing byte accepted at t; do_valid at t+1.
  - Output register clears when do_valid&do_ready, unless a new completion loads it in the same cycle.
- Channels are independent; simultaneous PDI/SDI/DO activity is legal with no arbitration.
- Reset mid-operation: partial words are lost. The external bench must restart the instruction.

Decomposition:
- Shared package lwc_pkg:
  - LWC_BYTE=8.
  - Functions nbytes(W)=W/8 and clog2-based cnt width.
  - Elaboration check that PW and SW are multiples of 8.
- One sub-module, lwc_downsizer (param W), instantiated for PDI and SDI.
- Upsizer stays inline in lwc_width_adapter.

Test Plan:
- PW=32: pdi_data=0xA1B2C3D4 with core_pdi_ready=1 -> core bytes A1,B2,C3,D4 on consecutive cycles; pdi_ready high in the D4 cycle. Second word 0x01020304 follows with no bubble.
- SW=32, core_sdi_ready toggling 1,0,1,0: key word 0x00112233 -> bytes 00,11,22,33 each held stable while stalled; sdi_ready stays 0 until 33 is consumed.
- PW=32, core bytes 11,22,33,44,55(last) -> DO words 0x11223344 (do_last=0), then 0x55000000 (do_last=1).
- do_ready=0 for 5 cycles after a full word -> core_do_ready=0 throughout and the word is held. Then do_ready=1 -> word accepted and core_do_ready=1 the same cycle.
- rst asserted after 2 of 4 PDI bytes -> all valids/readies 0 during reset. After release, pdi_ready=1, core_pdi_valid=0, and the new word starts at byte 0.
- PW=SW=8 regression -> byte-for-byte pass-through with one cycle latency, matching the legacy byte-wide wrapper.
